// File: rtl/ddr3_cmd_sequencer.sv
// Single-rank DDR3 command sequencer: power-up/MRS/ZQ init, periodic refresh, closed-page RD/WR.
// Optional build macro DDR3_ODT_EN enables RTT_nom in MR1 and drives odt around write bursts.
module ddr3_cmd_sequencer #(
    parameter int ADDR_BITS  = 14,
    parameter int BA_BITS    = 3,
    parameter int COL_BITS   = 10,
    parameter int T_INIT_RST = 100,
    parameter int T_INIT_CKE = 250,
    parameter int T_XPR      = 60,
    parameter int T_MRD      = 4,
    parameter int T_MOD      = 12,
    parameter int T_ZQINIT   = 512,
    parameter int T_RCD      = 6,
    parameter int T_RP       = 6,
    parameter int T_WR       = 6,
    parameter int T_RFC      = 44,
    parameter int T_REFI     = 3120,
    parameter int CL         = 6,
    parameter int CWL        = 5
) (
    input  logic                 ck,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BA_BITS-1:0]   req_bank,
    input  logic [ADDR_BITS-1:0] req_row,
    input  logic [COL_BITS-1:0]  req_col,
    output logic                 init_done,
    output logic                 ddr_rst_n,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output logic [BA_BITS-1:0]   ba,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 odt,
    output logic                 wr_data_en,
    output logic                 rd_data_en
);

    typedef enum logic [3:0] {
        ST_RST_LOW, ST_CKE_LOW, ST_XPR, ST_MR2, ST_MR3, ST_MR1, ST_MR0,
        ST_ZQ, ST_IDLE, ST_ACT, ST_RECOVER, ST_REF
    } state_t;

    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_ZQ  = 4'b0110;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_DES = 4'b1111;

    // Recovery is counted from the RD/WR cycle; the strobes are decoded from the same counter.
    localparam logic [15:0] RD_LEN   = 16'(CL + 4 + T_RP);
    localparam logic [15:0] WR_LEN   = 16'(CWL + 4 + T_WR + T_RP);
    localparam logic [15:0] WR_EN_HI = WR_LEN - 16'd1 - 16'(CWL);
    localparam logic [15:0] WR_EN_LO = WR_EN_HI - 16'd3;
    localparam logic [15:0] RD_EN_HI = RD_LEN - 16'd1 - 16'(CL);
    localparam logic [15:0] RD_EN_LO = RD_EN_HI - 16'd3;
`ifdef DDR3_ODT_EN
    localparam logic [15:0] ODT_LO   = WR_EN_LO - 16'd1;
`endif
    localparam int WR_CODE = (T_WR <= 8) ? (T_WR - 4) : (T_WR / 2);

    state_t                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d, ref_cnt_q, ref_cnt_d;
    logic                   ref_pending_q, ref_pending_d, ref_set_s, ref_clr_s;
    logic                   init_done_q, init_done_d, ddr_rst_n_q, ddr_rst_n_d, cke_q, cke_d;
    logic [3:0]             cmd_q, cmd_d;
    logic [BA_BITS-1:0]     ba_q, ba_d, bank_q, bank_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [COL_BITS-1:0]    col_q, col_d;
    logic                   we_lat_q, we_lat_d;
    logic                   odt_q, odt_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [ADDR_BITS-1:0]   mr0_s, mr1_s, mr2_s, zq_s, col_addr_s;

    assign req_ready = (state_q == ST_IDLE) && init_done_q && !ref_pending_q;

    // Mode-register images and the BL8-aligned, auto-precharge column address.
    always_comb begin
        mr2_s      = '0;
        mr2_s[5:3] = 3'(CWL - 5);
        mr1_s      = '0;
`ifdef DDR3_ODT_EN
        mr1_s[2]   = 1'b1;
`endif
        mr0_s       = '0;
        mr0_s[8]    = 1'b1;
        mr0_s[6:4]  = 3'(CL - 4);
        mr0_s[11:9] = 3'(WR_CODE);
        zq_s        = '0;
        zq_s[10]    = 1'b1;
        col_addr_s  = '0;
        col_addr_s[COL_BITS-1:0] = {col_q[COL_BITS-1:3], col_q[2:0] & 3'b000};
        col_addr_s[10] = 1'b1;
        col_addr_s[12] = 1'b1;
    end

    // Next-state, shared wait counter, refresh timer and command bus.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ref_cnt_d   = ref_cnt_q;
        ref_set_s   = 1'b0;
        ref_clr_s   = 1'b0;
        init_done_d = init_done_q;
        ddr_rst_n_d = ddr_rst_n_q;
        cke_d       = cke_q;
        cmd_d       = cke_q ? CMD_NOP : CMD_DES;
        ba_d        = '0;
        addr_d      = '0;
        we_lat_d    = we_lat_q;
        bank_d      = bank_q;
        col_d       = col_q;

        if (init_done_q) begin
            if (ref_cnt_q == 16'd0) begin
                ref_set_s = 1'b1;
                ref_cnt_d = 16'(T_REFI - 1);
            end else begin
                ref_cnt_d = ref_cnt_q - 16'd1;
            end
        end else begin
            ref_cnt_d = ref_cnt_q;
        end

        case (state_q)
            ST_RST_LOW: if (cnt_q == 16'd0) begin
                ddr_rst_n_d = 1'b1;
                state_d = ST_CKE_LOW;
                cnt_d = 16'(T_INIT_CKE - 1);
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            ST_CKE_LOW: if (cnt_q == 16'd0) begin
                cke_d = 1'b1;
                cmd_d = CMD_NOP;
                state_d = ST_XPR;
                cnt_d = 16'(T_XPR - 1);
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            ST_XPR: if (cnt_q == 16'd0) begin
                cmd_d = CMD_MRS; ba_d = BA_BITS'(2); addr_d = mr2_s;
                state_d = ST_MR2;
                cnt_d = 16'(T_MRD - 1);
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            ST_MR2: if (cnt_q == 16'd0) begin
                cmd_d = CMD_MRS; ba_d = BA_BITS'(3);
                state_d = ST_MR3;
                cnt_d = 16'(T_MRD - 1);
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            ST_MR3: if (cnt_q == 16'd0) begin
                cmd_d = CMD_MRS; ba_d = BA_BITS'(1); addr_d = mr1_s;
                state_d = ST_MR1;
                cnt_d = 16'(T_MRD - 1);
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            ST_MR1: if (cnt_q == 16'd0) begin
                cmd_d = CMD_MRS; addr_d = mr0_s;
                state_d = ST_MR0;
                cnt_d = 16'(T_MOD - 1);
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            ST_MR0: if (cnt_q == 16'd0) begin
                cmd_d = CMD_ZQ; addr_d = zq_s;
                state_d = ST_ZQ;
                cnt_d = 16'(T_ZQINIT - 1);
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            ST_ZQ: if (cnt_q == 16'd0) begin
                init_done_d = 1'b1;
                ref_cnt_d = 16'(T_REFI - 1);
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            // A pending refresh always wins over a new request while idle.
            ST_IDLE: if (ref_pending_q) begin
                cmd_d = CMD_REF;
                ref_clr_s = 1'b1;
                state_d = ST_REF;
                cnt_d = 16'(T_RFC - 1);
            end else if (req_valid && req_ready) begin
                cmd_d = CMD_ACT; ba_d = req_bank; addr_d = req_row;
                we_lat_d = req_we; bank_d = req_bank; col_d = req_col;
                state_d = ST_ACT;
                cnt_d = 16'(T_RCD - 1);
            end else begin
                state_d = ST_IDLE;
            end
            ST_ACT: if (cnt_q == 16'd0) begin
                cmd_d = we_lat_q ? CMD_WR : CMD_RD;
                ba_d = bank_q; addr_d = col_addr_s;
                state_d = ST_RECOVER;
                cnt_d = we_lat_q ? (WR_LEN - 16'd1) : (RD_LEN - 16'd1);
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            ST_RECOVER, ST_REF: if (cnt_q == 16'd0) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            default: state_d = ST_RST_LOW;
        endcase

        ref_pending_d = (ref_pending_q & ~ref_clr_s) | ref_set_s;
    end

    // Data-window strobes and odt, decoded from the next recovery count so they come out registered.
    always_comb begin
        wr_en_d = (state_d == ST_RECOVER) && we_lat_d && (cnt_d <= WR_EN_HI) && (cnt_d >= WR_EN_LO);
        rd_en_d = (state_d == ST_RECOVER) && !we_lat_d && (cnt_d <= RD_EN_HI) && (cnt_d >= RD_EN_LO);
`ifdef DDR3_ODT_EN
        odt_d   = (state_d == ST_RECOVER) && we_lat_d && (cnt_d >= ODT_LO);
`else
        odt_d   = 1'b0;
`endif
    end

    // All sequencer state and pin registers.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RST_LOW;
            cnt_q         <= 16'(T_INIT_RST);
            ref_cnt_q     <= 16'd0;
            ref_pending_q <= 1'b0;
            init_done_q   <= 1'b0;
            ddr_rst_n_q   <= 1'b0;
            cke_q         <= 1'b0;
            cmd_q         <= CMD_DES;
            ba_q          <= '0;
            addr_q        <= '0;
            bank_q        <= '0;
            col_q         <= '0;
            we_lat_q      <= 1'b0;
            odt_q         <= 1'b0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            init_done_q   <= init_done_d;
            ddr_rst_n_q   <= ddr_rst_n_d;
            cke_q         <= cke_d;
            cmd_q         <= cmd_d;
            ba_q          <= ba_d;
            addr_q        <= addr_d;
            bank_q        <= bank_d;
            col_q         <= col_d;
            we_lat_q      <= we_lat_d;
            odt_q         <= odt_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
        end
    end

    assign init_done  = init_done_q;
    assign ddr_rst_n  = ddr_rst_n_q;
    assign cke        = cke_q;
    assign cs_n       = cmd_q[3];
    assign ras_n      = cmd_q[2];
    assign cas_n      = cmd_q[1];
    assign we_n       = cmd_q[0];
    assign ba         = ba_q;
    assign addr       = addr_q;
    assign odt        = odt_q;
    assign wr_data_en = wr_en_q;
    assign rd_data_en = rd_en_q;

endmodule
